axis_i2c_rx: RTL and testbench

//  I2C target (write-only) that receives bytes from the I2C master and emits them as AXI-Stream words.

---
 rtl/axis_i2c_rx.sv | 193 +++++++++++++++++++
 tb/tb_axis_i2c_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_i2c_rx.sv
// Write-only I2C target: oversamples SCL/SDA, ACKs its own address and
// packs received bytes MSB-first into AXI-Stream words.
module axis_i2c_rx #(
  parameter int unsigned AXIS_DATA_WIDTH = 16,
  parameter logic [6:0]  DEV_ADDR        = 7'h50,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic                       i2c_scl,
  input  logic                       i2c_sda,
  output logic                       i2c_sda_oe,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                       busy,
  output logic                       overflow
);

  localparam int unsigned BYTES = AXIS_DATA_WIDTH / 8;
  localparam int unsigned BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_IGNORE
  } state_t;

  state_t                     state_q, state_d;
  logic [SYNC_STAGES-1:0]     scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0]     sda_sync_q, sda_sync_d;
  logic                       scl_prev_q, scl_prev_d;
  logic                       sda_prev_q, sda_prev_d;
  logic [2:0]                 bit_cnt_q, bit_cnt_d;
  logic [6:0]                 shift_q, shift_d;
  logic [BCW-1:0]             byte_cnt_q, byte_cnt_d;
  logic [AXIS_DATA_WIDTH-1:0] word_q, word_d;
  logic                       ack_on_q, ack_on_d;
  logic                       oe_q, oe_d;
  logic                       tvalid_q, tvalid_d;
  logic [AXIS_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                       busy_q, busy_d;
  logic                       ovf_q, ovf_d;

  logic                       scl_s, sda_s;
  logic                       scl_rise, scl_fall, sda_rise, sda_fall;
  logic                       start_c, stop_c;
  logic [7:0]                 rx_byte;
  logic [AXIS_DATA_WIDTH-1:0] word_nx;

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  assign sda_rise = sda_s & ~sda_prev_q;
  assign sda_fall = ~sda_s & sda_prev_q;
  assign start_c  = sda_fall & scl_s;
  assign stop_c   = sda_rise & scl_s;
  assign rx_byte  = {shift_q, sda_s};

  // Current partial word with the incoming byte dropped into its slot
  always_comb begin
    word_nx = word_q;
    for (int k = 0; k < int'(BYTES); k++) begin
      if (byte_cnt_q == BCW'(k)) begin
        word_nx[AXIS_DATA_WIDTH-1-8*k -: 8] = rx_byte;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], i2c_scl};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], i2c_sda};
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    ack_on_d   = ack_on_q;
    oe_d       = oe_q;
    tvalid_d   = tvalid_q & ~m_axis_tready;
    tdata_d    = tdata_q;
    busy_d     = busy_q;
    ovf_d      = ovf_q;

    if (start_c || stop_c) begin
      state_d    = start_c ? ST_ADDR : ST_IDLE;
      busy_d     = start_c;
      bit_cnt_d  = 3'd0;
      byte_cnt_d = '0;
      ack_on_d   = 1'b0;
      oe_d       = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = (rx_byte[7:1] == DEV_ADDR && !rx_byte[0]) ? ST_ADDR_ACK : ST_IGNORE;
            end
          end
        end
        ST_DATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (byte_cnt_q != LAST_BYTE) begin
                word_d     = word_nx;
                byte_cnt_d = byte_cnt_q + BCW'(1);
                state_d    = ST_DATA_ACK;
              end else if (!tvalid_q || m_axis_tready) begin
                tdata_d    = word_nx;
                tvalid_d   = 1'b1;
                byte_cnt_d = '0;
                state_d    = ST_DATA_ACK;
              end else begin
                // Output register still full: NACK and wait for the master's STOP
                ovf_d   = 1'b1;
                state_d = ST_IGNORE;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (scl_fall) begin
            if (!ack_on_q) begin
              oe_d     = 1'b1;
              ack_on_d = 1'b1;
            end else begin
              oe_d      = 1'b0;
              ack_on_d  = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = ST_DATA;
            end
          end
        end
        ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q    <= ST_IDLE;
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      bit_cnt_q  <= 3'd0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      ack_on_q   <= 1'b0;
      oe_q       <= 1'b0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      ack_on_q   <= ack_on_d;
      oe_q       <= oe_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
    end
  end

  assign i2c_sda_oe    = oe_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign busy          = busy_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_axis_i2c_rx.sv
// Directed bench for axis_i2c_rx: a behavioural I2C master drives an
// open-drain bus model, received words are logged from the AXIS side.
module tb_axis_i2c_rx;

  localparam int Q = 80;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        sda_bus;
  logic        i2c_sda_oe;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [15:0] m_axis_tdata;
  logic        busy;
  logic        overflow;

  int          total = 0;
  int          bad = 0;
  int          oe_cyc = 0;
  logic [15:0] words[$];

  assign sda_bus = m_sda & ~i2c_sda_oe;

  always #5 clk = ~clk;

  axis_i2c_rx dut (
    .clk           (clk),
    .arst          (arst),
    .i2c_scl       (scl),
    .i2c_sda       (sda_bus),
    .i2c_sda_oe    (i2c_sda_oe),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .busy          (busy),
    .overflow      (overflow)
  );

  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready) words.push_back(m_axis_tdata);
    if (i2c_sda_oe) oe_cyc <= oe_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; scl = 1'b1; #(Q);
    m_sda = 1'b0; #(Q);
    scl = 1'b0; #(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #(Q);
    scl = 1'b1; #(Q);
    m_sda = 1'b1; #(Q);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; #(Q);
    scl = 1'b1; #(2*Q);
    scl = 1'b0; #(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1; #(Q);
    scl = 1'b1; #(Q);
    ack = ~sda_bus; #(Q);
    scl = 1'b0; #(Q);
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic a0, a1, a2, a3, a4;
    int   nw, oe0;

    clocks(4);
    arst = 1'b0;
    clocks(2);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_oe", 32'(i2c_sda_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_tdata", 32'(m_axis_tdata), 32'd0);

    // T1: addressed write of two bytes
    nw = words.size();
    oe0 = oe_cyc;
    i2c_start();
    chk("t1_busy", 32'(busy), 32'd1);
    send_byte(8'hA0, a0);
    send_byte(8'hA5, a1);
    send_byte(8'h5A, a2);
    chk("t1_ack_addr", 32'(a0), 32'd1);
    chk("t1_ack_d0", 32'(a1), 32'd1);
    chk("t1_ack_d1", 32'(a2), 32'd1);
    i2c_stop();
    clocks(4);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_nwords", 32'(words.size() - nw), 32'd1);
    if (words.size() > nw) chk("t1_word", 32'(words[nw]), 32'h0000A55A);
    chk("t1_oe_seen", 32'(oe_cyc > oe0), 32'd1);
    chk("t1_tvalid", 32'(m_axis_tvalid), 32'd0);

    // T2: other address, never driven
    nw = words.size();
    oe0 = oe_cyc;
    i2c_start();
    send_byte(8'hA2, a0);
    send_byte(8'h12, a1);
    send_byte(8'h34, a2);
    chk("t2_busy", 32'(busy), 32'd1);
    i2c_stop();
    clocks(4);
    chk("t2_acks", 32'({a0, a1, a2}), 32'd0);
    chk("t2_oe", 32'(oe_cyc - oe0), 32'd0);
    chk("t2_nwords", 32'(words.size() - nw), 32'd0);
    chk("t2_busy_end", 32'(busy), 32'd0);

    // T3: read request to own address is NACKed
    nw = words.size();
    i2c_start();
    send_byte(8'hA1, a0);
    send_byte(8'h77, a1);
    send_byte(8'h88, a2);
    i2c_stop();
    clocks(4);
    chk("t3_acks", 32'({a0, a1, a2}), 32'd0);
    chk("t3_nwords", 32'(words.size() - nw), 32'd0);

    // T4: output stalled, fourth byte overflows
    m_axis_tready = 1'b0;
    nw = words.size();
    i2c_start();
    send_byte(8'hA0, a0);
    send_byte(8'h11, a1);
    send_byte(8'h22, a2);
    send_byte(8'h33, a3);
    send_byte(8'h44, a4);
    chk("t4_acks", 32'({a0, a1, a2, a3, a4}), 32'b11110);
    chk("t4_tvalid", 32'(m_axis_tvalid), 32'd1);
    chk("t4_tdata", 32'(m_axis_tdata), 32'h00001122);
    chk("t4_ovf", 32'(overflow), 32'd1);
    i2c_stop();
    clocks(4);
    m_axis_tready = 1'b1;
    clocks(6);
    chk("t4_nwords", 32'(words.size() - nw), 32'd1);
    if (words.size() > nw) chk("t4_word", 32'(words[nw]), 32'h00001122);
    chk("t4_tvalid_end", 32'(m_axis_tvalid), 32'd0);

    // T5: odd byte discarded at STOP, next transfer starts clean
    nw = words.size();
    i2c_start();
    send_byte(8'hA0, a0);
    send_byte(8'hAB, a1);
    i2c_stop();
    clocks(4);
    chk("t5_odd_nwords", 32'(words.size() - nw), 32'd0);
    chk("t5_acks", 32'({a0, a1}), 32'b11);
    i2c_start();
    send_byte(8'hA0, a0);
    send_byte(8'h01, a1);
    send_byte(8'h02, a2);
    i2c_stop();
    clocks(4);
    chk("t5_nwords", 32'(words.size() - nw), 32'd1);
    if (words.size() > nw) chk("t5_word", 32'(words[nw]), 32'h00000102);
    chk("t5_ovf_sticky", 32'(overflow), 32'd1);

    // T6: reset mid-byte, then a clean transfer
    i2c_start();
    send_byte(8'hA0, a0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(posedge clk);
    #1 arst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    chk("t6_oe", 32'(i2c_sda_oe), 32'd0);
    chk("t6_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("t6_tdata", 32'(m_axis_tdata), 32'd0);
    arst = 1'b0;
    clocks(2);
    i2c_stop();
    nw = words.size();
    i2c_start();
    send_byte(8'hA0, a0);
    send_byte(8'hCA, a1);
    send_byte(8'hFE, a2);
    i2c_stop();
    clocks(4);
    chk("t6_acks", 32'({a0, a1, a2}), 32'b111);
    chk("t6_nwords", 32'(words.size() - nw), 32'd1);
    if (words.size() > nw) chk("t6_word", 32'(words[nw]), 32'h0000CAFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
